// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through note words in an external synchronous melody
// memory and drives a square wave on speaker for each note's pitch and duration.
// Optional feature macro: ARTICULATION_GAP_EN -- when defined, every note is
// followed by GAP_CYCLES clocks of silence (GAP state); when undefined notes
// run back to back (legato).
module melody_sequencer #(
  parameter int TEMPO_DIV  = 1_200_000,
  parameter int ADDR_W     = 8,
  parameter int GAP_CYCLES = 120_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] note_addr,
  input  logic [23:0]       note_data,
  output logic              speaker,
  output logic              busy,
  output logic              done
);

  localparam int TICK_W = (TEMPO_DIV > 1) ? $clog2(TEMPO_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TEMPO_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
`ifdef ARTICULATION_GAP_EN
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              spk_q, spk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [19:0]       hp_q, hp_d;
  logic [19:0]       tone_q, tone_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        unit_q, unit_d;
`ifdef ARTICULATION_GAP_EN
  logic [GAP_W-1:0]  gap_q, gap_d;
`endif

  logic [3:0]  nd_dur;
  logic [19:0] nd_hp;
  assign nd_dur = note_data[23:20];
  assign nd_hp  = note_data[19:0];

  // Next-state logic: stop aborts any active state; otherwise walk the note FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    spk_d   = spk_q;
    done_d  = 1'b0;
    hp_d    = hp_q;
    tone_d  = tone_q;
    tick_d  = tick_q;
    unit_d  = unit_q;
`ifdef ARTICULATION_GAP_EN
    gap_d   = gap_q;
`endif
    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = '0;
      spk_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          spk_d = 1'b0;
          if (start && !stop) begin
            state_d = S_FETCH;
            addr_d  = '0;
          end
        end
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          if (nd_dur == 4'd0) begin
            // End marker: either rewind and keep going, or finish.
            addr_d = '0;
            if (loop) begin
              state_d = S_FETCH;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            hp_d    = nd_hp;
            tone_d  = nd_hp - 20'd1;
            tick_d  = TICK_MAX;
            unit_d  = nd_dur - 4'd1;
            spk_d   = 1'b0;
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          // Tone generator; a zero half-period is a rest and stays silent.
          if (hp_q == 20'd0) begin
            spk_d = 1'b0;
          end else if (tone_q == 20'd0) begin
            spk_d  = ~spk_q;
            tone_d = hp_q - 20'd1;
          end else begin
            tone_d = tone_q - 20'd1;
          end
          // Duration: tick wraps every TEMPO_DIV clocks, units count down.
          if (tick_q == '0) begin
            if (unit_q == 4'd0) begin
              spk_d = 1'b0;
`ifdef ARTICULATION_GAP_EN
              state_d = S_GAP;
              gap_d   = GAP_MAX;
`else
              state_d = S_FETCH;
              addr_d  = addr_q + ADDR_W'(1);
`endif
            end else begin
              unit_d = unit_q - 4'd1;
              tick_d = TICK_MAX;
            end
          end else begin
            tick_d = tick_q - TICK_W'(1);
          end
        end
`ifdef ARTICULATION_GAP_EN
        S_GAP: begin
          spk_d = 1'b0;
          if (gap_q == '0) begin
            state_d = S_FETCH;
            addr_d  = addr_q + ADDR_W'(1);
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          spk_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hp_q    <= '0;
      tone_q  <= '0;
      tick_q  <= '0;
      unit_q  <= '0;
`ifdef ARTICULATION_GAP_EN
      gap_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      spk_q   <= spk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hp_q    <= hp_d;
      tone_q  <= tone_d;
      tick_q  <= tick_d;
      unit_q  <= unit_d;
`ifdef ARTICULATION_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign note_addr = addr_q;
  assign speaker   = spk_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/melody_sequencer.md
# melody_sequencer

Note-sequencing controller for the music box tone path. Fetches note words from an external synchronous melody memory, drives a square wave on `speaker` at each note's pitch for its duration, and advances through the melody until an end marker. It handles play, stop and loop, and reports completion. It sits between the melody ROM and the speaker pin, clocked from the 12 MHz board clock.

## Interface
- `TEMPO_DIV`, default 1_200_000: clocks per duration unit (100 ms at 12 MHz); must be ≥ 1.
- `ADDR_W`, default 8: melody memory address width.
- `GAP_CYCLES`, default 120_000: silent clocks inserted after each note when the gap feature is compiled in; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: system clock, 12 MHz.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin playback from address 0. Sampled only in IDLE.
- `stop`  in  1: abort playback. Takes priority over `start`.
- `loop`  in  1: on end marker, restart from address 0 instead of finishing. Sampled at the end marker.
- `note_addr`  out  ADDR_W: melody memory address.
- `note_data`  in  24: note word returned one cycle after `note_addr` is presented.
  - [19:0] half-period in clocks; 0 means rest.
  - [23:20] duration in units; 0 means end-of-melody marker.
- `speaker`  out  1: square-wave audio output.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when the melody finishes without looping.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, GAP. GAP exists only with the macro below.
- Reset values: state=IDLE, `note_addr`=0, `speaker`=0, `busy`=0, `done`=0. All counters are cleared.
- IDLE
  - `speaker`=0.
  - `start`=1 and `stop`=0: go to FETCH with `note_addr`=0.
- FETCH
  - Lasts one cycle while the memory registers `note_addr`. Always goes to LOAD.
- LOAD (`note_data` is valid in this cycle)
  - Duration=0 and `loop`=1: `note_addr`←0, go to FETCH.
  - Duration=0 and `loop`=0: pulse `done`, `note_addr`←0, go to IDLE.
  - Otherwise: latch the half-period, set the tone counter to half-period−1, set the tick counter to TEMPO_DIV−1, set the unit counter to duration−1, go to PLAY.
- PLAY
  - Tone counter decrements each clock. On reaching 0 it toggles `speaker` and reloads half-period−1.
  - Rest notes (half-period=0): `speaker` is held 0 and no toggling occurs.
  - The tick counter wraps every TEMPO_DIV clocks. On each wrap the unit counter decrements.
  - When the last tick of the last unit is reached, force `speaker`=0 and go to GAP. Without the gap feature, increment `note_addr` and go to FETCH.
- GAP
  - Counts GAP_CYCLES clocks with `speaker`=0, then increments `note_addr` and goes to FETCH.
- `note_addr` increment wraps from 2^ADDR_W−1 to 0 with no error indication.
- `stop`=1 in any non-IDLE state:
  - Next state is IDLE with `speaker`=0 and `note_addr`=0.
  - No `done` pulse.
- `start` while busy is ignored. `start` and `stop` asserted together in IDLE leave the block in IDLE.
- Arithmetic rules:
  - Counters are sized to their maxima: 20 bits for tone, clog2(TEMPO_DIV) bits for tick, 4 bits for units.
  - All comparisons are unsigned with no saturation.

## Timing
- `start` is sampled at edge N. Then FETCH runs in cycle N+1, LOAD in N+2, and the first PLAY cycle is N+3.
- Note length: PLAY occupies exactly duration×TEMPO_DIV cycles.
- Note-to-note spacing:
  - Without the gap feature, the next note's first PLAY cycle follows the previous note's last PLAY cycle by 3 cycles (FETCH, LOAD, then PLAY).
  - With the gap feature, the spacing is GAP_CYCLES+3.
- First `speaker` edge: `speaker` rises after half-period PLAY cycles. The tone period is 2×half-period.
- `done` is asserted in the cycle after LOAD sees the end marker, coincident with `busy` falling.
- `rst` mid-note: outputs reach reset values at the next edge, with no `done` pulse.
- All outputs are registered.

## Configuration
- `ARTICULATION_GAP_EN` defined:
  - The GAP state is present.
  - Every note is followed by GAP_CYCLES of silence, so repeated identical pitches are audibly separated.
- `ARTICULATION_GAP_EN` undefined:
  - The GAP state and its counter are removed.
  - PLAY goes directly to FETCH, and notes are legato.

## Test plan
Bench parameters: TEMPO_DIV=10, GAP_CYCLES=4, ADDR_W=4, and a 1-cycle-latency model memory.
- Reset, then idle for 50 cycles -> `speaker`=0, `busy`=0, `note_addr`=0, `done` never high.
- Memory[0]={dur 2, hp 3}, memory[1]=end marker, `loop`=0, pulse `start` -> the following must all hold:
  - PLAY lasts 20 cycles, starting 3 cycles after `start`.
  - `speaker` toggles every 3 cycles.
  - After GAP (macro on), `done` pulses once and `busy` falls.
- Memory[0]={dur 1, hp 0} (rest), memory[1]=end marker -> `speaker` stays 0 throughout and `done` pulses.
- `loop`=1 with a 2-note melody -> `note_addr` sequence 0,1,2,0,1,2… and `done` never pulses. Then `stop` -> IDLE on the next edge, `speaker`=0, no `done`.
- 16 nonzero notes with no end marker -> `note_addr` wraps from 15 to 0 and playback continues.
- `rst` asserted mid-PLAY while `speaker`=1 -> all outputs reach reset values at the next edge. Rerun the 2-note melody with the macro undefined -> note-to-note spacing is exactly 3 cycles.
